// File: rtl/snn_spike_input_feeder.sv
// Host-to-grid spike feeder: FWFT packet FIFO grouped into tick frames, one tick per closed frame.
// Optional statistics counters are enabled by defining SNN_FEEDER_STATS_EN.
module snn_spike_input_feeder #(
   parameter int PACKET_WIDTH = 30,
   parameter int DEPTH        = 64,
   parameter int TICK_GAP     = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      host_valid,
   output logic                      host_ready,
   input  logic [PACKET_WIDTH-1:0]   host_packet,
   input  logic                      host_last,
   input  logic                      host_null,
   output logic [PACKET_WIDTH-1:0]   packet_in,
   output logic                      input_buffer_empty,
   input  logic                      ren_to_input_buffer,
   output logic                      tick,
   input  logic                      tick_ready,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      underflow_error
`ifdef SNN_FEEDER_STATS_EN
   ,
   output logic [31:0]               pkt_forwarded_cnt,
   output logic [31:0]               tick_issued_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = PACKET_WIDTH + 2;
   localparam int GW = $clog2(TICK_GAP + 1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_STREAM    = 2'd0,
      ST_TICK_WAIT = 2'd1,
      ST_TICK      = 2'd2,
      ST_GAP       = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            underflow_q, underflow_d;
   logic [EW-1:0]   mem_q [DEPTH];

   logic [EW-1:0]   head_s;
   logic            head_last_s;
   logic            head_null_s;
   logic            nonempty_s;
   logic            offer_s;
   logic            grid_pop_s;
   logic            null_pop_s;
   logic            pop_s;
   logic            push_s;

   assign head_s      = mem_q[rd_ptr_q];
   assign head_last_s = head_s[PACKET_WIDTH];
   assign head_null_s = head_s[PACKET_WIDTH+1];
   assign nonempty_s  = (count_q != {CW{1'b0}});
   assign offer_s     = (state_q == ST_STREAM) && nonempty_s && !head_null_s;
   assign grid_pop_s  = offer_s && ren_to_input_buffer;
   // A null head closes its frame without ever being offered to the grid.
   assign null_pop_s  = (state_q == ST_STREAM) && nonempty_s && head_null_s;
   assign pop_s       = grid_pop_s || null_pop_s;
   // A full FIFO still accepts a push in the same cycle as a pop.
   assign host_ready  = (count_q != FULL_C) || pop_s;
   assign push_s      = host_valid && host_ready;

   assign packet_in          = nonempty_s ? head_s[PACKET_WIDTH-1:0] : {PACKET_WIDTH{1'b0}};
   assign input_buffer_empty = !offer_s;
   assign tick               = (state_q == ST_TICK);
   assign fifo_count         = count_q;
   assign underflow_error    = underflow_q;

   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      underflow_d = underflow_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (ren_to_input_buffer && !offer_s) begin
         underflow_d = 1'b1;
      end else begin
         underflow_d = underflow_q;
      end

      case (state_q)
         ST_STREAM: begin
            if (null_pop_s || (grid_pop_s && head_last_s)) begin
               state_d = ST_TICK_WAIT;
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_TICK_WAIT: begin
            if (tick_ready) begin
               state_d = ST_TICK;
            end else begin
               state_d = ST_TICK_WAIT;
            end
         end
         ST_TICK: begin
            state_d = ST_GAP;
            gap_d   = GW'(TICK_GAP - 1);
         end
         ST_GAP: begin
            if (gap_q == {GW{1'b0}}) begin
               state_d = ST_STREAM;
            end else begin
               gap_d   = gap_q - GW'(1);
            end
         end
         default: state_d = ST_STREAM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_STREAM;
         gap_q       <= {GW{1'b0}};
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset so it can map onto RAM; pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s && !reset) begin
         mem_q[wr_ptr_q] <= {host_null, host_last, host_packet};
      end
   end

`ifdef SNN_FEEDER_STATS_EN
   logic [31:0] fwd_cnt_q;
   logic [31:0] tick_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fwd_cnt_q  <= 32'd0;
         tick_cnt_q <= 32'd0;
      end else begin
         fwd_cnt_q  <= grid_pop_s ? (fwd_cnt_q + 32'd1) : fwd_cnt_q;
         tick_cnt_q <= (state_q == ST_TICK) ? (tick_cnt_q + 32'd1) : tick_cnt_q;
      end
   end

   assign pkt_forwarded_cnt = fwd_cnt_q;
   assign tick_issued_cnt   = tick_cnt_q;
`endif

endmodule

// File: tb/tb_snn_spike_input_feeder.sv
// Randomized and directed bench for snn_spike_input_feeder against a queue-based frame model.
// Stats checks are compiled in when SNN_FEEDER_STATS_EN is defined.
module tb_snn_spike_input_feeder;

   localparam int PW    = 30;
   localparam int DEPTH = 64;
   localparam int GAP   = 2;

   logic            clk;
   logic            reset;
   logic            host_valid;
   logic            host_ready;
   logic [PW-1:0]   host_packet;
   logic            host_last;
   logic            host_null;
   logic [PW-1:0]   packet_in;
   logic            input_buffer_empty;
   logic            ren_to_input_buffer;
   logic            tick;
   logic            tick_ready;
   logic [6:0]      fifo_count;
   logic            underflow_error;
`ifdef SNN_FEEDER_STATS_EN
   logic [31:0]     pkt_forwarded_cnt;
   logic [31:0]     tick_issued_cnt;
`endif

   snn_spike_input_feeder #(.PACKET_WIDTH(PW), .DEPTH(DEPTH), .TICK_GAP(GAP)) dut (
      .clk                 (clk),
      .reset               (reset),
      .host_valid          (host_valid),
      .host_ready          (host_ready),
      .host_packet         (host_packet),
      .host_last           (host_last),
      .host_null           (host_null),
      .packet_in           (packet_in),
      .input_buffer_empty  (input_buffer_empty),
      .ren_to_input_buffer (ren_to_input_buffer),
      .tick                (tick),
      .tick_ready          (tick_ready),
      .fifo_count          (fifo_count),
      .underflow_error     (underflow_error)
`ifdef SNN_FEEDER_STATS_EN
      ,
      .pkt_forwarded_cnt   (pkt_forwarded_cnt),
      .tick_issued_cnt     (tick_issued_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Model: FIFO contents as {null,last,packet}; frame/tick progress as flags and a hold-off count.
   logic [31:0] mq[$];
   bit          m_wait;
   bit          m_tick;
   int          m_hold;
   bit          m_uf;
   int unsigned m_fwd;
   int unsigned m_ticks;
   int          seen_tick;
   int          seen_offer;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_wait  = 1'b0;
      m_tick  = 1'b0;
      m_hold  = 0;
      m_uf    = 1'b0;
      m_fwd   = 0;
      m_ticks = 0;
   endtask

   // Inputs are set by the caller just after a falling edge; compare, advance model, move one cycle.
   task automatic step(input bit chk_en);
      logic [31:0] head;
      bit have, can_stream, offer, pop, closes, hr;
      #1;
      have       = (mq.size() > 0);
      head       = have ? mq[0] : 32'd0;
      can_stream = !m_wait && !m_tick && (m_hold == 0);
      offer      = can_stream && have && !head[31];
      pop        = can_stream && have && (head[31] || ren_to_input_buffer);
      hr         = (mq.size() < DEPTH) || pop;
      if (chk_en) begin
         check_val("tick", tick, m_tick);
         check_val("ibe", input_buffer_empty, !offer);
         check_val("pkt", packet_in, head[PW-1:0]);
         check_val("count", fifo_count, mq.size());
         check_val("hready", host_ready, hr);
         check_val("uflow", underflow_error, m_uf);
`ifdef SNN_FEEDER_STATS_EN
         check_val("fwd_cnt", pkt_forwarded_cnt, m_fwd);
         check_val("tick_cnt", tick_issued_cnt, m_ticks);
`endif
      end
      seen_tick  += int'(tick);
      seen_offer += int'(!input_buffer_empty);
      if (reset) begin
         model_clear();
      end else begin
         if (ren_to_input_buffer && !offer) m_uf = 1'b1;
         if (offer && ren_to_input_buffer) m_fwd++;
         closes = pop && (head[30] || head[31]);
         if (pop) void'(mq.pop_front());
         if (host_valid && hr) mq.push_back({host_null, host_last, 30'(host_packet)});
         if (m_tick) begin
            m_ticks++;
            m_tick = 1'b0;
            m_hold = GAP;
         end else if (m_hold > 0) begin
            m_hold--;
         end else if (m_wait && tick_ready) begin
            m_wait = 1'b0;
            m_tick = 1'b1;
         end
         if (closes) m_wait = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      host_valid          = 1'b0;
      host_packet         = '0;
      host_last           = 1'b0;
      host_null           = 1'b0;
      ren_to_input_buffer = 1'b0;
      reset               = 1'b0;
   endtask

   task automatic push(input logic [PW-1:0] p, input bit last, input bit nul);
      host_valid  = 1'b1;
      host_packet = p;
      host_last   = last;
      host_null   = nul;
      step(1'b1);
      host_valid  = 1'b0;
      host_last   = 1'b0;
      host_null   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step(1'b0);
      step(1'b0);
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      #1;
      check_val({tag, "_tick"}, tick, 1'b0);
      check_val({tag, "_ibe"}, input_buffer_empty, 1'b1);
      check_val({tag, "_pkt"}, packet_in, '0);
      check_val({tag, "_uf"}, underflow_error, 1'b0);
      check_val({tag, "_hr"}, host_ready, 1'b1);
      check_val({tag, "_cnt"}, fifo_count, 7'd0);
   endtask

   initial begin
      idle_inputs();
      tick_ready = 1'b1;
      model_clear();
      @(negedge clk);
      do_reset();
      check_reset_state("rst");

      // Frame A,B,C with the grid popping every cycle.
      seen_tick = 0;
      ren_to_input_buffer = 1'b1;
      push(30'hA, 1'b0, 1'b0);
      push(30'hB, 1'b0, 1'b0);
      push(30'hC, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1);
      check_val("abc_ticks", seen_tick, 1);

      // Null+last frame alone.
      seen_tick  = 0;
      seen_offer = 0;
      push(30'h0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1);
      check_val("null_ticks", seen_tick, 1);
      check_val("null_offers", seen_offer, 0);
      check_val("null_count", fifo_count, 7'd0);

      // Tick held off while frame 2 is queued behind.
      tick_ready = 1'b0;
      push(30'h11, 1'b0, 1'b0);
      push(30'h12, 1'b1, 1'b0);
      step(1'b1);
      seen_tick  = 0;
      seen_offer = 0;
      push(30'h21, 1'b0, 1'b0);
      push(30'h22, 1'b0, 1'b0);
      push(30'h23, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) step(1'b1);
      check_val("hold_ticks", seen_tick, 0);
      check_val("hold_offers", seen_offer, 0);
      tick_ready = 1'b1;
      for (int i = 0; i < 15; i++) step(1'b1);
      check_val("hold_release_ticks", seen_tick, 2);

      // Fill with grid stalled, then stream through a full FIFO across pointer wrap.
      ren_to_input_buffer = 1'b0;
      for (int i = 0; i < DEPTH; i++) push(30'($urandom), 1'b0, 1'b0);
      host_valid = 1'b1;
      host_packet = 30'h3ABCDEF;
      #1;
      check_val("full_ready", host_ready, 1'b0);
      check_val("full_count", fifo_count, 7'd64);
      step(1'b1);
      ren_to_input_buffer = 1'b1;
      for (int i = 0; i < 80; i++) begin
         host_packet = 30'($urandom);
         step(1'b1);
      end
      check_val("full_stream_count", fifo_count, 7'd64);

      // Drain then pop from empty.
      host_valid = 1'b0;
      for (int i = 0; i < 70; i++) step(1'b1);
      check_val("uf_set", underflow_error, 1'b1);
      check_val("uf_count", fifo_count, 7'd0);

      // Reset mid-frame while a tick is pending.
      tick_ready = 1'b0;
      push(30'h31, 1'b0, 1'b0);
      push(30'h32, 1'b1, 1'b0);
      push(30'h41, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1);
      reset = 1'b1;
      step(1'b1);
      idle_inputs();
      tick_ready = 1'b1;
      check_reset_state("midrst");
      seen_tick = 0;
      for (int i = 0; i < 10; i++) step(1'b1);
      check_val("midrst_ticks", seen_tick, 0);

      // Three frames of five packets.
      do_reset();
      ren_to_input_buffer = 1'b1;
      seen_tick = 0;
      for (int f = 0; f < 3; f++)
         for (int p = 0; p < 5; p++) push(30'($urandom), (p == 4), 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1);
      check_val("stats_frame_ticks", seen_tick, 3);
`ifdef SNN_FEEDER_STATS_EN
      check_val("stats_fwd", pkt_forwarded_cnt, 32'd15);
      check_val("stats_ticks", tick_issued_cnt, 32'd3);
`endif

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r                   = int'($urandom_range(0, 99));
         host_valid          = ($urandom_range(0, 99) < 60);
         host_packet         = 30'($urandom);
         host_null           = (r < 8);
         host_last           = (r < 30);
         ren_to_input_buffer = ($urandom_range(0, 99) < 70);
         tick_ready          = ($urandom_range(0, 99) < 80);
         reset               = ($urandom_range(0, 999) < 4);
         step(1'b1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
